// File: rtl/load_pkg.sv
// Shared types and decode helpers for the MIPS32 little-endian load unit:
// op/state encodings, byteenable generation and the misalignment check.
package load_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LWL = 3'b010,
        OP_LW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_LWR = 3'b110,
        OP_ILL = 3'b111
    } load_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } load_state_t;

    // Byte lanes touched by a load at byte offset k within the word.
    function automatic logic [3:0] byte_enable(input load_op_t op, input logic [1:0] k);
        logic [4:0] lwl_mask;
        lwl_mask = (5'b00010 << k) - 5'd1;
        case (op)
            OP_LB, OP_LBU: byte_enable = 4'b0001 << k;
            OP_LH, OP_LHU: byte_enable = k[1] ? 4'b1100 : 4'b0011;
            OP_LW:         byte_enable = 4'b1111;
            OP_LWL:        byte_enable = lwl_mask[3:0];
            OP_LWR:        byte_enable = 4'b1111 << k;
            default:       byte_enable = 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input load_op_t op, input logic [1:0] k);
        case (op)
            OP_LH, OP_LHU: is_misaligned = k[0];
            OP_LW:         is_misaligned = (k != 2'b00);
            default:       is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane extraction, sign/zero extension and lwl/lwr merge of
// a 32-bit read word into the register write-back value.
module load_align
    import load_pkg::*;
(
    input  load_op_t    i_op,
    input  logic [1:0]  i_k,
    input  logic [31:0] i_readdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_data
);

    logic [4:0]  w_sh_r;
    logic [4:0]  w_sh_l;
    logic [31:0] w_shr;
    logic [15:0] w_half;

    // 3-k is the bitwise inverse of a 2-bit k, so lwl shifts by {~k, 000}.
    assign w_sh_r = {i_k, 3'b000};
    assign w_sh_l = {~i_k, 3'b000};
    assign w_shr  = i_readdata >> w_sh_r;
    assign w_half = i_k[1] ? i_readdata[31:16] : i_readdata[15:0];

    always_comb begin
        // NOTE: default assigned first so every path drives o_data; no latch.
        o_data = '0;
        case (i_op)
            OP_LB:   o_data = {{24{w_shr[7]}}, w_shr[7:0]};
            OP_LBU:  o_data = {24'h000000, w_shr[7:0]};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0000, w_half};
            OP_LW:   o_data = i_readdata;
            OP_LWL:  o_data = (i_readdata << w_sh_l) | (i_rt & ~(32'hFFFF_FFFF << w_sh_l));
            OP_LWR:  o_data = w_shr | (i_rt & ~(32'hFFFF_FFFF >> w_sh_r));
            default: ;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Sequential load engine: accepts one load, issues a word-aligned Avalon-MM
// read with optional waitrequest timeout, returns the aligned write-back value.
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_rt,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    load_state_t       r_state;
    load_state_t       w_state_next;
    logic              r_avm_read;
    logic [ADDR_W-1:0] r_avm_address;
    logic [3:0]        r_avm_be;
    load_op_t          r_op;
    logic [1:0]        r_k;
    logic [31:0]       r_rt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;

    load_op_t          w_req_op;
    logic [1:0]        w_req_k;
    logic              w_accept;
    logic              w_req_bad;
    logic              w_data_ok;
    logic              w_timeout;
    logic [31:0]       w_aligned;

    assign w_req_op  = load_op_t'(req_op);
    assign w_req_k   = req_addr[1:0];
    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_req_bad = (w_req_op == OP_ILL) || is_misaligned(w_req_op, w_req_k);
    assign w_data_ok = (r_state == ST_READ) && !avm_waitrequest;
    // Arriving data takes priority: timeout only fires while still stalled.
    assign w_timeout = (TIMEOUT > 0) && (r_state == ST_READ) && avm_waitrequest
                       && (r_wait_cnt == TIMEOUT_CNT);

    load_align u_align (
        .i_op       (r_op),
        .i_k        (r_k),
        .i_readdata (avm_readdata),
        .i_rt       (r_rt),
        .o_data     (w_aligned)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_req_bad ? ST_RESP : ST_READ;
            ST_READ: if (w_data_ok || w_timeout) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_read    <= 1'b0;
            r_avm_address <= '0;
            r_avm_be      <= 4'b0000;
            r_op          <= OP_LB;
            r_k           <= 2'b00;
            r_rt          <= '0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_req_bad) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            r_avm_read    <= 1'b1;
                            r_avm_address <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_avm_be      <= byte_enable(w_req_op, w_req_k);
                            r_op          <= w_req_op;
                            r_k           <= w_req_k;
                            r_rt          <= req_rt;
                            r_wait_cnt    <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (w_data_ok) begin
                        r_avm_read  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_aligned;
                    end else if (w_timeout) begin
                        r_avm_read  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end else if (r_wait_cnt != {CNT_W{1'b1}}) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign avm_read       = r_avm_read;
    assign avm_address    = r_avm_address;
    assign avm_byteenable = r_avm_be;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit (TIMEOUT=4): expected responses are queued
// when a load is driven and compared when rsp_valid pulses.
module tb_load_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_rt = '0;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest = 1'b0;
    logic [31:0]       avm_readdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    load_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_rt          (req_rt),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Called at a negedge with the unit idle. Slave stalls nwait cycles.
    task automatic run_load(input string name, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [31:0] rdata, input int nwait,
                            input logic [3:0] exp_be, input logic [31:0] exp_data,
                            input logic exp_err, input int exp_lat, input int exp_reads);
        exp_t e;
        int   lat;
        int   reads;
        int   waits;
        lat = 0; reads = 0; waits = 0;
        e.data = exp_data;
        e.err  = exp_err;
        sb_q.push_back(e);
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rt    = rt;
        @(posedge clk);
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            req_valid       = 1'b0;
            avm_waitrequest = 1'b0;
            avm_readdata    = 32'h0;
            if (rsp_valid) begin
                lat = c;
            end else if (avm_read) begin
                reads++;
                check({name, "_be"}, {28'd0, avm_byteenable}, {28'd0, exp_be});
                check({name, "_addr"}, avm_address, {addr[31:2], 2'b00});
                if (waits < nwait) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = 32'hDEAD_BEEF;
                    waits++;
                end else begin
                    avm_readdata = rdata;
                end
            end
        end
        if (lat == 0) begin
            check({name, "_no_rsp"}, 32'd0, 32'd1);
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_reads"}, reads, exp_reads);
        @(negedge clk);
        avm_waitrequest = 1'b0;
        check({name, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_be", {28'd0, avm_byteenable}, 32'd0);
        check("rst_addr", avm_address, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        //       name      op      addr          rt            rdata         nw   be       data          err lat reads
        run_load("lb_k3",  3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,  4'b1000, 32'hFFFF_FF80, 0, 2, 1);
        run_load("lbu_k3", 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,  4'b1000, 32'h0000_0080, 0, 2, 1);
        run_load("lhu_w3", 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 3,  4'b1100, 32'h0000_BEEF, 0, 5, 4);
        run_load("lwl_k1", 3'b010, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 0,  4'b0011, 32'hCCDD_3344, 0, 2, 1);
        run_load("lwr_k1", 3'b110, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 0,  4'b1110, 32'h11AA_BBCC, 0, 2, 1);
        run_load("lw_mis", 3'b011, 32'h0000_0102, 32'h0,        32'h1234_5678, 0,  4'b1111, 32'h0000_0000, 1, 1, 0);
        run_load("lw_to",  3'b011, 32'h0000_4000, 32'h0,        32'h1234_5678, 100, 4'b1111, 32'h0000_0000, 1, 6, 5);
        run_load("lw_w4",  3'b011, 32'h0000_4004, 32'h0,        32'h1234_5678, 4,  4'b1111, 32'h1234_5678, 0, 6, 5);
        run_load("lh_k2",  3'b001, 32'h0000_5002, 32'h0,        32'h8001_7FFF, 1,  4'b1100, 32'hFFFF_8001, 0, 3, 2);
        run_load("lh_mis", 3'b001, 32'h0000_5001, 32'h0,        32'h8001_7FFF, 0,  4'b0000, 32'h0000_0000, 1, 1, 0);
        run_load("op_ill", 3'b111, 32'h0000_5000, 32'h0,        32'h8001_7FFF, 0,  4'b0000, 32'h0000_0000, 1, 1, 0);
        run_load("lhu_k0", 3'b101, 32'h0000_6000, 32'h0,        32'h1234_ABCD, 0,  4'b0011, 32'h0000_ABCD, 0, 2, 1);
        run_load("lwl_k3", 3'b010, 32'h0000_6003, 32'h1111_1111, 32'hCAFE_F00D, 0,  4'b1111, 32'hCAFE_F00D, 0, 2, 1);
        run_load("lwr_k0", 3'b110, 32'h0000_6000, 32'h1111_1111, 32'hCAFE_F00D, 0,  4'b1111, 32'hCAFE_F00D, 0, 2, 1);
        run_load("lwr_k3", 3'b110, 32'h0000_6003, 32'h1122_3344, 32'hAABB_CCDD, 2,  4'b1000, 32'h1122_33AA, 0, 4, 3);
        run_load("lb_k0",  3'b000, 32'h0000_7000, 32'h0,        32'h0000_007F, 0,  4'b0001, 32'h0000_007F, 0, 2, 1);

        // Reset in the middle of a stalled read: no response may follow.
        req_valid = 1'b1;
        req_op    = 3'b011;
        req_addr  = 32'h0000_8000;
        @(posedge clk);
        @(negedge clk);
        req_valid       = 1'b0;
        avm_waitrequest = 1'b1;
        check("mid_read", {31'd0, avm_read}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_read", {31'd0, avm_read}, 32'd0);
        check("abort_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        avm_waitrequest = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        run_load("post_rst", 3'b100, 32'h0000_9001, 32'h0, 32'h0000_F500, 0, 4'b0010, 32'h0000_00F5, 0, 2, 1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
